// File: rtl/branch_resolve_if.sv
// Signal bundle between the EX-stage branch resolver and the pipeline around it
// (decode/EX registers, comparator, hazard unit, PC mux).
interface branch_resolve_if #(
  parameter int CNT_W = 32
);
  logic             ex_valid;
  logic             ex_is_branch;
  logic             ex_is_jump;
  logic [2:0]       ex_funct3;
  logic [31:0]      ex_pc;
  logic [31:0]      ex_target;
  logic             ex_pred_taken;
  logic             BrEq;
  logic             BrLT;
  logic             BrUn;
  logic             stall_in;
  logic [31:0]      if_pc;
  logic             if_pred_taken;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;

  modport master (
    output ex_valid, ex_is_branch, ex_is_jump, ex_funct3, ex_pc, ex_target,
           ex_pred_taken, BrEq, BrLT, stall_in, if_pc,
    input  BrUn, if_pred_taken, redirect_valid, redirect_pc, flush_if_id,
           flush_id_ex, branch_cnt, mispredict_cnt
  );

  modport slave (
    input  ex_valid, ex_is_branch, ex_is_jump, ex_funct3, ex_pc, ex_target,
           ex_pred_taken, BrEq, BrLT, stall_in, if_pc,
    output BrUn, if_pred_taken, redirect_valid, redirect_pc, flush_if_id,
           flush_id_ex, branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// EX-stage branch resolution: decodes comparator flags, checks the bimodal
// prediction and issues a one-shot registered redirect/flush on mispredict.
module branch_resolve_ctrl #(
  parameter int IDX_W = 6,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  branch_resolve_if.slave bus
);

  typedef enum logic {IDLE, REDIRECT} state_t;

  localparam int N_ENT = 2 ** IDX_W;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_redirect;
  logic [31:0]      r_redirect_pc;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_mispredict_cnt;

  logic             w_br_taken;
  logic             w_actual;
  logic             w_resolve;
  logic             w_mispredict;
  logic             w_bht_we;
  logic [IDX_W-1:0] w_upd_idx;
  logic [IDX_W-1:0] w_rd_idx;
  logic [1:0]       w_upd_cur;
  logic [1:0]       w_upd_next;
  logic [1:0]       w_bht [N_ENT];
  logic             w_unused;

  assign bus.BrUn = bus.ex_funct3[1];

  always_comb begin
    w_br_taken = 1'b0;
    case (bus.ex_funct3)
      3'b000:  w_br_taken = bus.BrEq;
      3'b001:  w_br_taken = !bus.BrEq;
      3'b100:  w_br_taken = bus.BrLT;
      3'b101:  w_br_taken = !bus.BrLT;
      3'b110:  w_br_taken = bus.BrLT;
      3'b111:  w_br_taken = !bus.BrLT;
      default: w_br_taken = 1'b0;
    endcase
  end

  // A jump wins over the branch flag when both are set.
  assign w_actual     = bus.ex_is_jump ? 1'b1 : w_br_taken;
  assign w_resolve    = bus.ex_valid & (bus.ex_is_branch | bus.ex_is_jump)
                        & !bus.stall_in & (r_state == IDLE);
  assign w_mispredict = w_actual != bus.ex_pred_taken;

  always_comb begin
    w_state_next = r_state;
    w_redirect   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_resolve && w_mispredict) w_state_next = REDIRECT;
      end
      REDIRECT: begin
        w_redirect = 1'b1;
        if (!bus.stall_in) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= IDLE;
      r_redirect_pc    <= '0;
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_resolve) begin
        r_branch_cnt <= r_branch_cnt + 1'b1;
        if (w_mispredict) begin
          r_mispredict_cnt <= r_mispredict_cnt + 1'b1;
          r_redirect_pc    <= w_actual ? bus.ex_target : bus.ex_pc + 32'd4;
        end
      end
    end
  end

  assign bus.redirect_valid = w_redirect;
  assign bus.flush_if_id    = w_redirect;
  assign bus.flush_id_ex    = w_redirect;
  assign bus.redirect_pc    = r_redirect_pc;
  assign bus.branch_cnt     = r_branch_cnt;
  assign bus.mispredict_cnt = r_mispredict_cnt;

  // Bimodal table: combinational lookup sees the pre-update counter value.
  assign w_rd_idx   = bus.if_pc[IDX_W+1:2];
  assign w_upd_idx  = bus.ex_pc[IDX_W+1:2];
  assign w_bht_we   = w_resolve & bus.ex_is_branch & !bus.ex_is_jump;
  assign w_upd_cur  = w_bht[w_upd_idx];
  assign w_upd_next = w_actual ? ((w_upd_cur == 2'b11) ? 2'b11 : w_upd_cur + 2'b01)
                               : ((w_upd_cur == 2'b00) ? 2'b00 : w_upd_cur - 2'b01);

  genvar gi;
  generate
    for (gi = 0; gi < N_ENT; gi++) begin : g_bht
      logic [1:0] r_cnt;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          r_cnt <= 2'b01;
        else if (w_bht_we && (w_upd_idx == IDX_W'(gi)))
          r_cnt <= w_upd_next;
      end
      assign w_bht[gi] = r_cnt;
    end
  endgenerate

  assign bus.if_pred_taken = w_bht[w_rd_idx][1];

  assign w_unused = ^{bus.if_pc[31:IDX_W+2], bus.if_pc[1:0]};

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed, table-driven bench for branch_resolve_ctrl plus hand-written
// sequences for stall, wrong-path, BHT saturation and reset corner cases.
module tb_branch_resolve_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   exp_br;
  int   exp_mis;

  branch_resolve_if #(.CNT_W(32)) bus ();

  branch_resolve_ctrl #(.IDX_W(6), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic        eq;
    logic        lt;
    logic        br;
    logic        jmp;
    logic        pred;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        exp_brun;
    logic        exp_mis;
    logic [31:0] exp_rpc;
  } vec_t;

  vec_t vt [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic eq, input logic lt,
                       input logic br, input logic jmp, input logic pred,
                       input logic [31:0] pc, input logic [31:0] tgt);
    bus.ex_valid      = 1'b1;
    bus.ex_funct3     = f3;
    bus.BrEq          = eq;
    bus.BrLT          = lt;
    bus.ex_is_branch  = br;
    bus.ex_is_jump    = jmp;
    bus.ex_pred_taken = pred;
    bus.ex_pc         = pc;
    bus.ex_target     = tgt;
  endtask

  task automatic check_redirect(input string name, input logic exp);
    check({name, " redirect_valid"}, {31'd0, bus.redirect_valid}, {31'd0, exp});
    check({name, " flush_if_id"},    {31'd0, bus.flush_if_id},    {31'd0, exp});
    check({name, " flush_id_ex"},    {31'd0, bus.flush_id_ex},    {31'd0, exp});
  endtask

  task automatic check_cnts(input string name);
    check({name, " branch_cnt"},     bus.branch_cnt,     exp_br);
    check({name, " mispredict_cnt"}, bus.mispredict_cnt, exp_mis);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; exp_br = 0; exp_mis = 0;
    rst = 1'b1;
    bus.ex_valid = 1'b0; bus.ex_is_branch = 1'b0; bus.ex_is_jump = 1'b0;
    bus.ex_funct3 = 3'b000; bus.ex_pc = '0; bus.ex_target = '0;
    bus.ex_pred_taken = 1'b0; bus.BrEq = 1'b0; bus.BrLT = 1'b0;
    bus.stall_in = 1'b0; bus.if_pc = '0;

    //          f3     eq lt br jmp pred pc            tgt           brun mis rpc
    vt[0]  = '{3'b000, 1, 0, 1, 0, 0, 32'h0000_0100, 32'h0000_0080, 0, 1, 32'h0000_0080};
    vt[1]  = '{3'b001, 1, 0, 1, 0, 0, 32'h0000_0200, 32'h0000_0300, 0, 0, 32'h0000_0000};
    vt[2]  = '{3'b001, 0, 0, 1, 0, 0, 32'h0000_0204, 32'h0000_0400, 0, 1, 32'h0000_0400};
    vt[3]  = '{3'b100, 0, 1, 1, 0, 1, 32'h0000_0208, 32'h0000_0480, 0, 0, 32'h0000_0000};
    vt[4]  = '{3'b101, 0, 1, 1, 0, 1, 32'h0000_020C, 32'h0000_0500, 0, 1, 32'h0000_0210};
    vt[5]  = '{3'b110, 0, 0, 1, 0, 1, 32'h0000_0210, 32'h0000_0600, 1, 1, 32'h0000_0214};
    vt[6]  = '{3'b111, 0, 0, 1, 0, 0, 32'h0000_0214, 32'h0000_0700, 1, 1, 32'h0000_0700};
    vt[7]  = '{3'b010, 1, 1, 1, 0, 1, 32'h0000_0218, 32'h0000_0800, 1, 1, 32'h0000_021C};
    vt[8]  = '{3'b011, 1, 1, 1, 0, 0, 32'h0000_021C, 32'h0000_0880, 1, 0, 32'h0000_0000};
    vt[9]  = '{3'b000, 0, 0, 0, 1, 0, 32'h0000_0220, 32'h0000_1000, 0, 1, 32'h0000_1000};
    vt[10] = '{3'b000, 0, 0, 1, 1, 1, 32'h0000_0224, 32'h0000_2000, 0, 0, 32'h0000_0000};

    // Reset state
    tick();
    check_redirect("reset", 1'b0);
    check("reset redirect_pc", bus.redirect_pc, 32'h0);
    check_cnts("reset");
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      bus.if_pc = i << 2;
      #1;
      check($sformatf("reset bht[%0d]", i), {31'd0, bus.if_pred_taken}, 32'd0);
    end
    bus.if_pc = '0;
    tick();

    // Table vectors: one resolve each, then let any redirect drain
    for (int v = 0; v < 11; v++) begin
      drive(vt[v].f3, vt[v].eq, vt[v].lt, vt[v].br, vt[v].jmp, vt[v].pred, vt[v].pc, vt[v].tgt);
      #1;
      check($sformatf("vec%0d BrUn", v), {31'd0, bus.BrUn}, {31'd0, vt[v].exp_brun});
      tick();
      bus.ex_valid = 1'b0;
      exp_br++;
      if (vt[v].exp_mis) exp_mis++;
      check_redirect($sformatf("vec%0d", v), vt[v].exp_mis);
      if (vt[v].exp_mis)
        check($sformatf("vec%0d redirect_pc", v), bus.redirect_pc, vt[v].exp_rpc);
      check_cnts($sformatf("vec%0d", v));
      tick();
      check_redirect($sformatf("vec%0d drain", v), 1'b0);
      $display("vec%0d f3=%b pc=%08h mis=%0d rpc=%08h", v, vt[v].f3, vt[v].pc,
               bus.mispredict_cnt, bus.redirect_pc);
    end

    // BGEU not taken at top of memory: PC+4 wraps; redirect held under stall
    drive(3'b111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_4000);
    #1;
    check("bgeu BrUn", {31'd0, bus.BrUn}, 32'd1);
    tick();
    exp_br++; exp_mis++;
    check_redirect("bgeu c1", 1'b1);
    check("bgeu redirect_pc", bus.redirect_pc, 32'h0000_0000);
    // Wrong-path mispredicting branch sits in EX while REDIRECT is held
    drive(3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0300, 32'h0000_0900);
    bus.stall_in = 1'b1;
    for (int c = 2; c <= 4; c++) begin
      tick();
      check_redirect($sformatf("bgeu stall c%0d", c), 1'b1);
      check($sformatf("bgeu stall c%0d redirect_pc", c), bus.redirect_pc, 32'h0000_0000);
    end
    bus.stall_in = 1'b0;
    tick();
    bus.ex_valid = 1'b0;
    check_redirect("bgeu release", 1'b0);
    check("wrong-path redirect_pc", bus.redirect_pc, 32'h0000_0000);
    check_cnts("wrong-path");
    $display("bgeu/stall/wrong-path done rpc=%08h br=%0d", bus.redirect_pc, bus.branch_cnt);

    // Mispredicting branch under stall in IDLE: no action
    drive(3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0300, 32'h0000_0A00);
    bus.stall_in = 1'b1;
    tick();
    bus.ex_valid = 1'b0;
    bus.stall_in = 1'b0;
    check_redirect("stalled resolve", 1'b0);
    check_cnts("stalled resolve");
    $display("stalled resolve br=%0d mis=%0d", bus.branch_cnt, bus.mispredict_cnt);

    // BHT: BNE taken with pred=1 at PC 0x40 (index 16)
    bus.if_pc = 32'h0000_0040;
    drive(3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0000_0C00);
    #1;
    check("same-index old value", {31'd0, bus.if_pred_taken}, 32'd0);
    tick();
    exp_br++;
    check_redirect("bne correct", 1'b0);
    check_cnts("bne correct");
    check("bht 01->10 pred", {31'd0, bus.if_pred_taken}, 32'd1);
    for (int k = 0; k < 3; k++) tick();
    exp_br += 3;
    bus.ex_valid = 1'b0;
    check_cnts("bht 4 taken");
    // A jump at the same PC must leave the entry alone
    drive(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0C00);
    tick();
    exp_br++;
    // First not-taken: saturated 11 -> 10, still predicts taken
    drive(3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0000_0C00);
    tick();
    bus.ex_valid = 1'b0;
    exp_br++; exp_mis++;
    check_redirect("bht nt1", 1'b1);
    check("bht nt1 redirect_pc", bus.redirect_pc, 32'h0000_0044);
    check("bht 11->10 pred", {31'd0, bus.if_pred_taken}, 32'd1);
    tick();
    // Second not-taken, predicted not-taken: 10 -> 01
    drive(3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0C00);
    tick();
    bus.ex_valid = 1'b0;
    exp_br++;
    check("bht 10->01 pred", {31'd0, bus.if_pred_taken}, 32'd0);
    check_cnts("bht final");
    $display("bht seq done br=%0d mis=%0d", bus.branch_cnt, bus.mispredict_cnt);

    // Reset in the middle of REDIRECT drops the outputs immediately
    drive(3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0500, 32'h0000_0E00);
    tick();
    bus.ex_valid = 1'b0;
    check_redirect("pre-rst", 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_redirect("mid-redirect rst", 1'b0);
    check("mid-redirect rst redirect_pc", bus.redirect_pc, 32'h0);
    exp_br = 0; exp_mis = 0;
    check_cnts("mid-redirect rst");
    tick();
    rst = 1'b0;
    tick();
    check_redirect("after rst", 1'b0);
    $display("reset mid-redirect done rv=%0d", bus.redirect_valid);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Sequences the EX-stage branch comparator for the pipelined RV32I core.
- Drives the comparator's unsigned-select from funct3 and decodes its equal/less-than flags into a taken decision.
- Checks that decision against the IF-stage prediction from an internal 2-bit bimodal table, then issues a registered PC redirect plus IF/ID and ID/EX flushes on mispredict.
- Sits between the decode/EX pipeline registers, the branch comparator, the hazard unit and the PC mux.

Parameters:
- IDX_W, 6: BHT index width; 2^IDX_W entries of 2-bit counters.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- ex_valid  in  1  EX stage holds a live instruction
- ex_is_branch  in  1  EX instruction is a conditional branch (B-type)
- ex_is_jump  in  1  EX instruction is JAL/JALR
- ex_funct3  in  3  EX instruction funct3
- ex_pc  in  32  EX instruction PC
- ex_target  in  32  computed branch/jump target
- ex_pred_taken  in  1  prediction carried down the pipe from IF
- BrEq  in  1  comparator equal flag
- BrLT  in  1  comparator less-than flag
- BrUn  out  1  comparator unsigned select
- stall_in  in  1  pipeline stall from hazard unit
- if_pc  in  32  current fetch PC
- if_pred_taken  out  1  BHT prediction for if_pc
- redirect_valid  out  1  PC mux must load redirect_pc
- redirect_pc  out  32  corrected fetch PC
- flush_if_id  out  1  kill IF/ID register
- flush_id_ex  out  1  kill ID/EX register
- branch_cnt  out  CNT_W  resolved branches and jumps
- mispredict_cnt  out  CNT_W  mispredicts

Behaviour:
- Reset, asynchronous, effective immediately:
  - FSM goes to IDLE.
  - redirect_valid, flush_if_id and flush_id_ex are 0; redirect_pc is 0.
  - Both counters are 0.
  - All BHT entries are 2'b01 (weakly not-taken).
- BrUn is combinational and equals ex_funct3[1] (high for BLTU/BGEU).
- Taken decode is combinational:
  - 000 → BrEq; 001 → !BrEq
  - 100 → BrLT; 101 → !BrLT
  - 110 → BrLT; 111 → !BrLT
  - 010 and 011 → not taken.
  - Jumps are always taken.
- resolve = ex_valid & (ex_is_branch | ex_is_jump) & !stall_in & state==IDLE.
- On resolve:
  - branch_cnt increments.
  - mispredict = (actual != ex_pred_taken).
  - On mispredict: mispredict_cnt increments; redirect_pc <= actual ? ex_target : ex_pc+4 (mod 2^32); FSM goes to REDIRECT.
- FSM IDLE:
  - All redirect/flush outputs are 0.
  - Leaves IDLE only on a mispredicting resolve.
- FSM REDIRECT:
  - redirect_valid, flush_if_id and flush_id_ex are all 1; latency is one cycle after the resolving edge.
  - If stall_in=1, stay in REDIRECT with outputs and redirect_pc held; no resolves occur.
  - If stall_in=0, return to IDLE next cycle; the asserted window is exactly 1 cycle when unstalled.
  - The EX instruction seen while in REDIRECT is wrong-path: no resolve, no counters, no BHT update.
- BHT lookup:
  - if_pred_taken = counter[if_pc[IDX_W+1:2]][1], combinational read.
- BHT update:
  - Happens on resolve with ex_is_branch only; jumps never touch the BHT.
  - Entry index is ex_pc[IDX_W+1:2]; increment if taken, decrement if not.
  - Counters saturate at 11 and 00.
- Same-cycle lookup and update of the same index: lookup returns the pre-update value (read-before-write).
- ex_is_branch and ex_is_jump both high: treated as a jump.
- Counters wrap at 2^CNT_W.
- Reset asserted mid-REDIRECT: outputs drop asynchronously and no redirect is completed.

Test Plan:
- After reset, read every BHT index via if_pc → if_pred_taken=0; all outputs 0 and counters 0.
- BEQ mispredict:
  - Stimulus: funct3=000, BrEq=1, ex_pred_taken=0, ex_pc=0x100, ex_target=0x80.
  - Response: BrUn=0; next cycle redirect_valid, flush_if_id and flush_id_ex high for exactly 1 cycle with redirect_pc=0x80.
  - Counters: branch_cnt=1, mispredict_cnt=1.
- BGEU not taken:
  - Stimulus: funct3=111, BrLT=1, pred=1, ex_pc=0xFFFFFFFC.
  - Response: BrUn=1; redirect_pc=0x00000000 (wrap).
  - Then stall_in=1 for 3 cycles → redirect held 4 cycles total.
- Correct prediction, BNE taken with pred=1:
  - No redirect; branch_cnt=1, mispredict_cnt=0.
  - BHT entry moves 01→10; next lookup of that PC gives if_pred_taken=1.
- Saturation: same PC resolved taken 4 times → counter stays 11; then 1 not-taken → 10, prediction still 1.
- Stall and wrong-path cases:
  - Resolve with stall_in=1 → no action.
  - A mispredicting branch presented in EX during REDIRECT is ignored.
  - Same-index lookup/update in one cycle → if_pred_taken shows the old value.
  - rst asserted mid-REDIRECT → redirect_valid falls immediately.
